// File: rtl/regfile_sb.sv
// Two-read/one-write register file with writeback bypass and a per-register
// busy scoreboard used by decode for read-after-write hazard detection.
module regfile_sb #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] AA,
  input  logic [ADDR_W-1:0] BA,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              issue,
  input  logic [ADDR_W-1:0] issue_da,
  input  logic              WR,
  input  logic [ADDR_W-1:0] DA,
  input  logic [DATA_W-1:0] data_in,
  output logic [ADDR_W:0]   pending_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   cnt_d;

  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      regs_d[r] = regs_q[r];
    end
    busy_d = busy_q;
    for (int r = 1; r < DEPTH; r++) begin
      if (WR && DA == ADDR_W'(r)) begin
        regs_d[r] = data_in;
      end
      // A new producer supersedes a writeback from the old one.
      if (issue && issue_da == ADDR_W'(r)) begin
        busy_d[r] = 1'b1;
      end else if (WR && DA == ADDR_W'(r)) begin
        busy_d[r] = 1'b0;
      end
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
    cnt_d = '0;
    for (int r = 0; r < DEPTH; r++) begin
      cnt_d = cnt_d + {{ADDR_W{1'b0}}, busy_d[r]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= regs_d[r];
      end
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];
  logic              rd_busy [2];

  assign rd_addr[0] = AA;
  assign rd_addr[1] = BA;

  // Outputs are held at zero during reset, bypass path included.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic rd_live;
    logic rd_hit;
    assign rd_live     = rst && (rd_addr[gi] != '0);
    assign rd_hit      = BYPASS && WR && (DA == rd_addr[gi]);
    assign rd_data[gi] = !rd_live ? '0 : (rd_hit ? data_in : regs_q[rd_addr[gi]]);
    assign rd_busy[gi] = rd_live && !rd_hit && busy_q[rd_addr[gi]];
  end

  assign data_a      = rd_data[0];
  assign data_b      = rd_data[1];
  assign busy_a      = rd_busy[0];
  assign busy_b      = rd_busy[1];
  assign pending_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb (default parameters, BYPASS=1).
module tb_regfile_sb;

  logic       clk;
  logic       rst;
  logic [2:0] AA, BA;
  logic [7:0] data_a, data_b;
  logic       busy_a, busy_b;
  logic       issue;
  logic [2:0] issue_da;
  logic       WR;
  logic [2:0] DA;
  logic [7:0] data_in;
  logic [3:0] pending_cnt;

  int total = 0;
  int bad   = 0;

  regfile_sb #(.DATA_W(8), .ADDR_W(3), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .AA(AA), .BA(BA),
    .data_a(data_a), .data_b(data_b), .busy_a(busy_a), .busy_b(busy_b),
    .issue(issue), .issue_da(issue_da), .WR(WR), .DA(DA), .data_in(data_in),
    .pending_cnt(pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scan_zero(input string tag);
    for (int a = 0; a < 8; a++) begin
      AA = 3'(a);
      BA = 3'(7 - a);
      #1;
      check($sformatf("%s data_a[%0d]", tag, a), 16'(data_a), 16'h0);
      check($sformatf("%s busy_a[%0d]", tag, a), 16'(busy_a), 16'h0);
      check($sformatf("%s data_b[%0d]", tag, 7 - a), 16'(data_b), 16'h0);
      check($sformatf("%s busy_b[%0d]", tag, 7 - a), 16'(busy_b), 16'h0);
    end
    check({tag, " pending"}, 16'(pending_cnt), 16'h0);
  endtask

  initial begin
    rst = 1'b0; AA = 3'd1; BA = 3'd1;
    issue = 1'b0; issue_da = '0;
    WR = 1'b1; DA = 3'd1; data_in = 8'h33;
    #2;
    check("rst bypass data_a", 16'(data_a), 16'h0);
    check("rst busy_a", 16'(busy_a), 16'h0);
    #5;
    check("rst after edge data_a", 16'(data_a), 16'h0);
    WR = 1'b0;
    #5;
    rst = 1'b1;
    step();
    scan_zero("post-reset");

    // Writes R1=5 (bypass visible same cycle), then R2=10
    WR = 1'b1; DA = 3'd1; data_in = 8'd5; AA = 3'd1;
    #1;
    check("bypass R1 data_a", 16'(data_a), 16'd5);
    check("bypass R1 busy_a", 16'(busy_a), 16'd0);
    step();
    DA = 3'd2; data_in = 8'd10;
    step();
    WR = 1'b0; AA = 3'd1; BA = 3'd2;
    #1;
    check("R1 data_a", 16'(data_a), 16'd5);
    check("R2 data_b", 16'(data_b), 16'd10);

    // R0 is immune to writes and issues
    WR = 1'b1; DA = 3'd0; data_in = 8'hFF; AA = 3'd0; BA = 3'd0;
    #1;
    check("R0 write bypass data_a", 16'(data_a), 16'h0);
    step();
    WR = 1'b0;
    #1;
    check("R0 data_a", 16'(data_a), 16'h0);
    check("R0 data_b", 16'(data_b), 16'h0);
    issue = 1'b1; issue_da = 3'd0;
    step();
    issue = 1'b0;
    #1;
    check("R0 issue pending", 16'(pending_cnt), 16'd0);
    check("R0 busy_a", 16'(busy_a), 16'd0);

    // Issue R3, then writeback 0x2A
    issue = 1'b1; issue_da = 3'd3; AA = 3'd3;
    #1;
    check("R3 busy same cycle", 16'(busy_a), 16'd0);
    step();
    issue = 1'b0;
    #1;
    check("R3 busy_a", 16'(busy_a), 16'd1);
    check("R3 pending", 16'(pending_cnt), 16'd1);
    WR = 1'b1; DA = 3'd3; data_in = 8'h2A;
    #1;
    check("R3 wb bypass data_a", 16'(data_a), 16'h2A);
    check("R3 wb bypass busy_a", 16'(busy_a), 16'd0);
    check("R3 wb pending before edge", 16'(pending_cnt), 16'd1);
    step();
    WR = 1'b0;
    #1;
    check("R3 data after wb", 16'(data_a), 16'h2A);
    check("R3 busy after wb", 16'(busy_a), 16'd0);
    check("R3 pending after wb", 16'(pending_cnt), 16'd0);

    // Same-cycle issue and writeback to R4: issue wins
    issue = 1'b1; issue_da = 3'd4; WR = 1'b1; DA = 3'd4; data_in = 8'd7;
    step();
    issue = 1'b0; WR = 1'b0; AA = 3'd4;
    #1;
    check("R4 data", 16'(data_a), 16'd7);
    check("R4 busy", 16'(busy_a), 16'd1);
    check("R4 pending", 16'(pending_cnt), 16'd1);

    // Fill R5..R7 with data, then issue R1..R7
    WR = 1'b1;
    for (int r = 5; r < 8; r++) begin
      DA = 3'(r); data_in = 8'(8'h11 * r);
      step();
    end
    WR = 1'b0;
    issue = 1'b1;
    for (int r = 1; r < 8; r++) begin
      issue_da = 3'(r);
      step();
    end
    issue = 1'b0; AA = 3'd7; BA = 3'd5;
    #1;
    check("all busy pending", 16'(pending_cnt), 16'd7);
    check("R7 data_a", 16'(data_a), 16'h77);
    check("R7 busy_a", 16'(busy_a), 16'd1);
    check("R5 data_b", 16'(data_b), 16'h55);
    check("R5 busy_b", 16'(busy_b), 16'd1);

    // Asynchronous reset mid-stream with writeback and issue pending
    WR = 1'b1; DA = 3'd6; data_in = 8'h99; AA = 3'd6; BA = 3'd2;
    issue = 1'b1; issue_da = 3'd2;
    #2;
    rst = 1'b0;
    #1;
    check("midrst data_a", 16'(data_a), 16'h0);
    check("midrst busy_a", 16'(busy_a), 16'h0);
    check("midrst data_b", 16'(data_b), 16'h0);
    check("midrst busy_b", 16'(busy_b), 16'h0);
    check("midrst pending", 16'(pending_cnt), 16'h0);
    step();
    check("midrst held pending", 16'(pending_cnt), 16'h0);
    WR = 1'b0; issue = 1'b0;
    #3;
    rst = 1'b1;
    step();
    scan_zero("post-midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
